// File: rtl/tdm_demux_1_4.sv
// Time-division demux: recovers four W-bit channels from a slot-0-framed serial stream.
// Build option TDM_DEMUX_FLYWHEEL_EN: tolerate a missing frame_sync at slot 0 instead of dropping lock.
module tdm_demux_1_4 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   input  logic         din_valid,
   input  logic         frame_sync,
   output logic [W-1:0] Y0,
   output logic [W-1:0] Y1,
   output logic [W-1:0] Y2,
   output logic [W-1:0] Y3,
   output logic         frame_valid,
   output logic [1:0]   slot,
   output logic         locked,
   output logic         sync_err
);

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t              state;
   logic [2:0][W-1:0]   shadow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HUNT;
         shadow      <= '0;
         Y0          <= '0;
         Y1          <= '0;
         Y2          <= '0;
         Y3          <= '0;
         frame_valid <= 1'b0;
         slot        <= 2'd0;
         locked      <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         if (din_valid) begin
            case (state)
               HUNT: begin
                  if (frame_sync) begin
                     shadow[0] <= din;
                     slot      <= 2'd1;
                     state     <= LOCKED;
                     locked    <= 1'b1;
                  end
               end
               LOCKED: begin
                  if (slot == 2'd0) begin
                     if (frame_sync) begin
                        shadow[0] <= din;
                        slot      <= 2'd1;
                     end else begin
`ifdef TDM_DEMUX_FLYWHEEL_EN
                        shadow[0] <= din;
                        slot      <= 2'd1;
`else
                        sync_err  <= 1'b1;
                        state     <= HUNT;
                        locked    <= 1'b0;
                        slot      <= 2'd0;
`endif
                     end
                  end else if (frame_sync) begin
                     // Early sync: drop the partial frame and restart on this beat.
                     sync_err  <= 1'b1;
                     shadow[0] <= din;
                     slot      <= 2'd1;
                  end else if (slot == 2'd3) begin
                     Y0          <= shadow[0];
                     Y1          <= shadow[1];
                     Y2          <= shadow[2];
                     Y3          <= din;
                     frame_valid <= 1'b1;
                     slot        <= 2'd0;
                  end else begin
                     if (slot == 2'd1) shadow[1] <= din;
                     else              shadow[2] <= din;
                     slot <= slot + 2'd1;
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Bench for tdm_demux_1_4 (W=4): directed vector table, corner sequences and a random run vs a frame-queue model.
module tb_tdm_demux_1_4;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] din = '0;
   logic         din_valid = 1'b0;
   logic         frame_sync = 1'b0;
   logic [W-1:0] Y0, Y1, Y2, Y3;
   logic         frame_valid, locked, sync_err;
   logic [1:0]   slot;

   int total = 0;
   int bad = 0;

   tdm_demux_1_4 #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
      .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .frame_valid(frame_valid), .slot(slot),
      .locked(locked), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   // Observed outputs packed as {Y3,Y2,Y1,Y0,frame_valid,sync_err,locked,slot}
   function automatic logic [20:0] obs();
      return {Y3, Y2, Y1, Y0, frame_valid, sync_err, locked, slot};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: beats of the current frame are collected in an array;
   // a frame is published when the fourth beat arrives.
   logic [W-1:0] fq[4];
   int           fq_n;
   bit           m_locked, m_fv, m_se;
   logic [W-1:0] my[4];

   task automatic model_reset();
      fq_n = 0; m_locked = 0; m_fv = 0; m_se = 0;
      for (int i = 0; i < 4; i++) begin my[i] = '0; fq[i] = '0; end
   endtask

   task automatic model_step(input bit v, input bit s, input logic [W-1:0] d);
      m_fv = 0; m_se = 0;
      if (!v) return;
      if (!m_locked) begin
         if (s) begin fq[0] = d; fq_n = 1; m_locked = 1; end
      end else if (s) begin
         if (fq_n != 0) m_se = 1;
         fq[0] = d; fq_n = 1;
      end else if (fq_n == 0) begin
`ifdef TDM_DEMUX_FLYWHEEL_EN
         fq[0] = d; fq_n = 1;
`else
         m_se = 1; m_locked = 0;
`endif
      end else begin
         fq[fq_n] = d;
         fq_n++;
         if (fq_n == 4) begin
            for (int i = 0; i < 4; i++) my[i] = fq[i];
            m_fv = 1; fq_n = 0;
         end
      end
   endtask

   function automatic logic [20:0] model_obs();
      return {my[3], my[2], my[1], my[0], m_fv, m_se, m_locked, 2'(fq_n)};
   endfunction

   // One clock of stimulus; inputs change #1 after the edge, outputs checked there too.
   task automatic beat(input string name, input bit v, input bit s, input logic [W-1:0] d);
      din_valid = v; frame_sync = s; din = d;
      @(posedge clk); #1;
      model_step(v, s, d);
      chk(name, 32'(obs()), 32'(model_obs()));
   endtask

   task automatic do_reset();
      din_valid = 0; frame_sync = 0; din = '0;
      rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      model_reset();
   endtask

   typedef struct {
      bit           v, s;
      logic [W-1:0] d;
      logic [W-1:0] y0, y1, y2, y3;
      bit           fv, se, lk;
      logic [1:0]   sl;
   } vec_t;

   vec_t vt[15];
   int   fv_cnt;

   initial begin
      // reset/hunt, normal frame, early sync, ignored sync while din_valid=0
      vt[0]  = '{1,0,4'h1, 4'h0,4'h0,4'h0,4'h0, 0,0,0,2'd0};
      vt[1]  = '{1,0,4'h2, 4'h0,4'h0,4'h0,4'h0, 0,0,0,2'd0};
      vt[2]  = '{1,0,4'h3, 4'h0,4'h0,4'h0,4'h0, 0,0,0,2'd0};
      vt[3]  = '{1,1,4'hA, 4'h0,4'h0,4'h0,4'h0, 0,0,1,2'd1};
      vt[4]  = '{1,0,4'hB, 4'h0,4'h0,4'h0,4'h0, 0,0,1,2'd2};
      vt[5]  = '{1,0,4'hC, 4'h0,4'h0,4'h0,4'h0, 0,0,1,2'd3};
      vt[6]  = '{1,0,4'hD, 4'hA,4'hB,4'hC,4'hD, 1,0,1,2'd0};
      vt[7]  = '{0,0,4'h0, 4'hA,4'hB,4'hC,4'hD, 0,0,1,2'd0};
      vt[8]  = '{1,1,4'h1, 4'hA,4'hB,4'hC,4'hD, 0,0,1,2'd1};
      vt[9]  = '{1,0,4'h2, 4'hA,4'hB,4'hC,4'hD, 0,0,1,2'd2};
      vt[10] = '{1,1,4'h5, 4'hA,4'hB,4'hC,4'hD, 0,1,1,2'd1};
      vt[11] = '{1,0,4'h6, 4'hA,4'hB,4'hC,4'hD, 0,0,1,2'd2};
      vt[12] = '{1,0,4'h7, 4'hA,4'hB,4'hC,4'hD, 0,0,1,2'd3};
      vt[13] = '{1,0,4'h8, 4'h5,4'h6,4'h7,4'h8, 1,0,1,2'd0};
      vt[14] = '{0,1,4'hF, 4'h5,4'h6,4'h7,4'h8, 0,0,1,2'd0};

      model_reset();
      #2;
      chk("reset_async", 32'(obs()), 32'h0);
      @(posedge clk); #1;
      rst_n = 1;
      chk("reset_state", 32'(obs()), 32'h0);

      for (int i = 0; i < 15; i++) begin
         din_valid = vt[i].v; frame_sync = vt[i].s; din = vt[i].d;
         @(posedge clk); #1;
         chk($sformatf("vec%0d", i), 32'(obs()),
             32'({vt[i].y3, vt[i].y2, vt[i].y1, vt[i].y0, vt[i].fv, vt[i].se, vt[i].lk, vt[i].sl}));
      end

      // Gaps: two idle cycles after every beat, exactly one frame_valid pulse.
      do_reset();
      fv_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         beat("gap_beat", 1, i == 0, 4'(4'hA + i));
         if (frame_valid) fv_cnt++;
         for (int g = 0; g < 2; g++) begin
            beat("gap_idle", 0, 0, 4'hF);
            if (frame_valid) fv_cnt++;
         end
      end
      chk("gap_fv_count", 32'(fv_cnt), 32'd1);
      chk("gap_y", 32'({Y3, Y2, Y1, Y0}), 32'hDCBA);

      // Missing sync at slot 0 after a full frame.
      do_reset();
      for (int i = 0; i < 4; i++) beat("miss_f1", 1, i == 0, 4'(i + 1));
      beat("miss_9", 1, 0, 4'h9);
`ifdef TDM_DEMUX_FLYWHEEL_EN
      chk("miss_no_err", 32'(sync_err), 32'd0);
`else
      chk("miss_err", 32'({sync_err, locked}), 32'b10);
`endif
      for (int i = 0; i < 3; i++) beat("miss_rest", 1, 0, 4'(4'hA + i));
`ifdef TDM_DEMUX_FLYWHEEL_EN
      chk("miss_y", 32'({Y3, Y2, Y1, Y0}), 32'hCBA9);
`else
      chk("miss_y", 32'({Y3, Y2, Y1, Y0}), 32'h4321);
`endif

      // Asynchronous reset between edges in the middle of a frame.
      for (int i = 0; i < 4; i++) beat("mid_f1", 1, i == 0, 4'(4'h3 + i));
      beat("mid_b0", 1, 1, 4'h1);
      beat("mid_b1", 1, 0, 4'h2);
      din_valid = 0; frame_sync = 0;
      #2 rst_n = 0;
      #1 chk("mid_rst_clear", 32'(obs()), 32'h0);
      #1 rst_n = 1;
      model_reset();
      for (int i = 0; i < 4; i++) beat("mid_after", 1, i == 0, 4'(4'hE + i));
      chk("mid_after_y", 32'({Y3, Y2, Y1, Y0}), 32'h10FE);

      // Random stimulus against the frame-queue model.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         bit v, s;
         v = ($urandom % 4) != 0;
         s = (fq_n == 0) ? (($urandom % 8) != 0) : (($urandom % 12) == 0);
         beat("rand", v, s, 4'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
